// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor.
// Holds the controller state encoding used by serial_subtractor.
package serial_subtractor_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

endpackage : serial_subtractor_pkg

// File: rtl/serial_subtractor_half_subtractor_cell.sv
// One-bit subtractor cell with borrow in: d = x - y - bin, bout = borrow out.
// Purely combinational; the caller registers the borrow between bits.
// Ports:
//   x    minuend bit
//   y    subtrahend bit
//   bin  borrow from the previous (less significant) bit
//   d    difference bit
//   bout borrow to the next (more significant) bit
module half_subtractor_cell (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = x ^ y ^ bin;
  assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule : half_subtractor_cell

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: Diff = A - B (mod 2^WIDTH), Borrow = (A < B).
// Operands are consumed LSB-first, one bit per clock, through a single
// subtractor cell with a registered borrow. Latency is WIDTH+1 clock edges.
// Ports:
//   Clk     rising-edge clock
//   Rst_n   asynchronous active-low reset
//   Start   request, sampled only while Busy=0 (IDLE or DONE)
//   A, B    operands, captured on the accepted Start edge
//   Busy    high while bits are being shifted (SHIFT state only)
//   Done    one-cycle pulse, result valid
//   Diff    difference, held until the next operation completes
//   Borrow  borrow out of bit WIDTH-1, held like Diff
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             Start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Diff,
  output logic             Borrow
);

  localparam int              CNT_W    = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  // Holds the WIDTH-1 low difference bits already produced; the final bit
  // comes straight from the cell on the last shift edge.
  logic [WIDTH-2:0] res_q, res_d;
  logic             borrow_q, borrow_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bout_q, bout_d;

  logic cell_d;
  logic cell_bout;

  half_subtractor_cell u_cell (
    .x    (a_q[0]),
    .y    (b_q[0]),
    .bin  (borrow_q),
    .d    (cell_d),
    .bout (cell_bout)
  );

  always_comb begin
    // NOTE: every variable gets its hold value first so no path through the
    // case leaves it unassigned, which would otherwise infer a latch.
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    res_d    = res_q;
    borrow_d = borrow_q;
    cnt_d    = cnt_q;
    diff_d   = diff_q;
    bout_d   = bout_q;

    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        // DONE always leaves after one cycle; a Start seen there restarts
        // directly into SHIFT without passing through IDLE.
        if (state_q == ST_DONE) state_d = ST_IDLE;
        if (Start) begin
          a_d      = A;
          b_d      = B;
          res_d    = '0;
          borrow_d = 1'b0;
          cnt_d    = '0;
          state_d  = ST_SHIFT;
        end
      end

      ST_SHIFT: begin
        a_d               = a_q >> 1;
        b_d               = b_q >> 1;
        res_d             = res_q >> 1;
        res_d[WIDTH-2]    = cell_d;
        borrow_d          = cell_bout;
        cnt_d             = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_BIT) begin
          diff_d  = {cell_d, res_q};
          bout_d  = cell_bout;
          state_d = ST_DONE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of the others; the shift registers are small enough
  // that clearing them on reset costs nothing and keeps outputs defined.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q  <= ST_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      borrow_q <= 1'b0;
      cnt_q    <= '0;
      diff_q   <= '0;
      bout_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      res_q    <= res_d;
      borrow_q <= borrow_d;
      cnt_q    <= cnt_d;
      diff_q   <= diff_d;
      bout_q   <= bout_d;
    end
  end

  assign Busy   = (state_q == ST_SHIFT);
  assign Done   = (state_q == ST_DONE);
  assign Diff   = diff_q;
  assign Borrow = bout_q;

endmodule : serial_subtractor
